// File: rtl/ibex_pkg.sv
// Shared types for the instruction aligner: FSM state encoding, counter limit
// and the compressed-instruction test on the two low opcode bits.
package ibex_pkg;

  typedef enum logic [1:0] {
    ALIGN_EMPTY,
    ALIGN_LO,
    ALIGN_HI,
    ALIGN_STRADDLE
  } aligner_state_e;

  localparam logic [31:0] PerfCntMax = 32'hFFFF_FFFF;

  function automatic logic half_is_compressed(input logic [15:0] half);
    return half[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/ibex_aligner_perf.sv
// Pair of saturating 32-bit counters for issued compressed / uncompressed
// instructions.
module ibex_aligner_perf
  import ibex_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_c,
  input  logic        inc_u,
  output logic [31:0] c_cnt,
  output logic [31:0] u_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_cnt <= 32'h0;
      u_cnt <= 32'h0;
    end else begin
      if (inc_c && (c_cnt != PerfCntMax)) begin
        c_cnt <= c_cnt + 32'd1;
      end
      if (inc_u && (u_cnt != PerfCntMax)) begin
        u_cnt <= u_cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/ibex_instr_aligner.sv
// Splits word-aligned fetch words into whole 16/32-bit instructions with PCs.
// Optional IBEX_ALIGNER_PERF_EN adds issued-instruction counters.
module ibex_instr_aligner
  import ibex_pkg::*;
#(
  parameter logic [31:0] ResetAddr = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_rdata_i,
  input  logic        fetch_err_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_rdata_o,
  output logic [31:0] out_addr_o,
  output logic        out_is_compressed_o,
  output logic        out_err_o
`ifdef IBEX_ALIGNER_PERF_EN
  ,
  output logic [31:0] perf_c_cnt_o,
  output logic [31:0] perf_u_cnt_o
`endif
);

  aligner_state_e state_q, state_d;
  logic [31:0]    buf_q, buf_d;
  logic           buf_err_q, buf_err_d;
  logic [15:0]    half_q, half_d;
  logic           half_err_q, half_err_d;
  logic [31:0]    pc_q, pc_d;
  logic           skip_q, skip_d;
  logic           consume;
  logic [31:0]    consume_step;
  logic           unused_addr_bit;

  // Instructions are halfword aligned, so the redirect target's bit 0 is dropped.
  assign unused_addr_bit = branch_addr_i[0];

  always_comb begin
    state_d             = state_q;
    buf_d               = buf_q;
    buf_err_d           = buf_err_q;
    half_d              = half_q;
    half_err_d          = half_err_q;
    pc_d                = pc_q;
    skip_d              = skip_q;
    consume             = 1'b0;
    consume_step        = 32'd0;
    fetch_ready_o       = 1'b0;
    out_valid_o         = 1'b0;
    out_rdata_o         = 32'h0;
    out_addr_o          = pc_q;
    out_is_compressed_o = 1'b0;
    out_err_o           = 1'b0;

    unique case (state_q)
      ALIGN_EMPTY: begin
        fetch_ready_o = 1'b1;
        if (fetch_valid_i) begin
          buf_d     = fetch_rdata_i;
          buf_err_d = fetch_err_i;
          if (skip_q) begin
            state_d = ALIGN_HI;
            skip_d  = 1'b0;
          end else begin
            state_d = ALIGN_LO;
          end
        end
      end

      ALIGN_LO: begin
        out_valid_o = 1'b1;
        if (buf_err_q) begin
          out_err_o = 1'b1;
          if (out_ready_i) begin
            state_d = ALIGN_EMPTY;
          end
        end else if (half_is_compressed(buf_q[15:0])) begin
          out_rdata_o         = {16'h0, buf_q[15:0]};
          out_is_compressed_o = 1'b1;
          if (out_ready_i) begin
            state_d = ALIGN_HI;
            pc_d    = pc_q + 32'd2;
          end
        end else begin
          out_rdata_o  = buf_q;
          consume      = 1'b1;
          consume_step = 32'd4;
        end
      end

      ALIGN_HI: begin
        if (buf_err_q) begin
          out_valid_o = 1'b1;
          out_err_o   = 1'b1;
          if (out_ready_i) begin
            state_d = ALIGN_EMPTY;
          end
        end else if (half_is_compressed(buf_q[31:16])) begin
          out_valid_o         = 1'b1;
          out_rdata_o         = {16'h0, buf_q[31:16]};
          out_is_compressed_o = 1'b1;
          consume             = 1'b1;
          consume_step        = 32'd2;
        end else begin
          // Lower half of a 32-bit instruction: park it and wait for the next word.
          fetch_ready_o = 1'b1;
          if (fetch_valid_i) begin
            half_d     = buf_q[31:16];
            half_err_d = buf_err_q;
            buf_d      = fetch_rdata_i;
            buf_err_d  = fetch_err_i;
            state_d    = ALIGN_STRADDLE;
          end
        end
      end

      ALIGN_STRADDLE: begin
        out_valid_o = 1'b1;
        out_rdata_o = {buf_q[15:0], half_q};
        out_err_o   = half_err_q | buf_err_q;
        if (out_ready_i) begin
          if (half_err_q | buf_err_q) begin
            state_d = ALIGN_EMPTY;
          end else begin
            state_d = ALIGN_HI;
            pc_d    = pc_q + 32'd4;
          end
        end
      end

      default: begin
        state_d = ALIGN_EMPTY;
      end
    endcase

    // The last instruction of the buffer lets a new word in during the same cycle.
    if (consume) begin
      fetch_ready_o = out_ready_i;
      if (out_ready_i) begin
        pc_d = pc_q + consume_step;
        if (fetch_valid_i) begin
          buf_d     = fetch_rdata_i;
          buf_err_d = fetch_err_i;
          state_d   = ALIGN_LO;
        end else begin
          state_d = ALIGN_EMPTY;
        end
      end
    end

    if (branch_i) begin
      fetch_ready_o = 1'b1;
      state_d       = ALIGN_EMPTY;
      pc_d          = {branch_addr_i[31:1], 1'b0};
      skip_d        = branch_addr_i[1];
      buf_d         = buf_q;
      buf_err_d     = buf_err_q;
      half_d        = half_q;
      half_err_d    = half_err_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ALIGN_EMPTY;
      buf_q      <= 32'h0;
      buf_err_q  <= 1'b0;
      half_q     <= 16'h0;
      half_err_q <= 1'b0;
      pc_q       <= ResetAddr;
      skip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_err_q  <= buf_err_d;
      half_q     <= half_d;
      half_err_q <= half_err_d;
      pc_q       <= pc_d;
      skip_q     <= skip_d;
    end
  end

`ifdef IBEX_ALIGNER_PERF_EN
  logic issue;

  assign issue = out_valid_o & out_ready_i & ~branch_i & ~out_err_o;

  ibex_aligner_perf u_perf (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .inc_c (issue & out_is_compressed_o),
    .inc_u (issue & ~out_is_compressed_o),
    .c_cnt (perf_c_cnt_o),
    .u_cnt (perf_u_cnt_o)
  );
`endif

endmodule

// File: tb/tb_ibex_instr_aligner.sv
// Self-checking bench for ibex_instr_aligner: directed scenarios plus random
// fetch streams checked against a halfword-walking reference model.
module tb_ibex_instr_aligner;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        fetch_valid_i = 1'b0;
  logic        fetch_ready_o;
  logic [31:0] fetch_rdata_i = 32'h0;
  logic        fetch_err_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = 32'h0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_rdata_o;
  logic [31:0] out_addr_o;
  logic        out_is_compressed_o;
  logic        out_err_o;
`ifdef IBEX_ALIGNER_PERF_EN
  logic [31:0] perf_c_cnt_o;
  logic [31:0] perf_u_cnt_o;
  int          perf_c_model = 0;
  int          perf_u_model = 0;
`endif

  always #5 clk_i = ~clk_i;

  ibex_instr_aligner #(.ResetAddr(32'h0000_0000)) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .fetch_valid_i       (fetch_valid_i),
    .fetch_ready_o       (fetch_ready_o),
    .fetch_rdata_i       (fetch_rdata_i),
    .fetch_err_i         (fetch_err_i),
    .branch_i            (branch_i),
    .branch_addr_i       (branch_addr_i),
    .out_valid_o         (out_valid_o),
    .out_ready_i         (out_ready_i),
    .out_rdata_o         (out_rdata_o),
    .out_addr_o          (out_addr_o),
    .out_is_compressed_o (out_is_compressed_o),
    .out_err_o           (out_err_o)
`ifdef IBEX_ALIGNER_PERF_EN
    ,
    .perf_c_cnt_o        (perf_c_cnt_o),
    .perf_u_cnt_o        (perf_u_cnt_o)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        comp;
    logic        err;
  } exp_t;

  int          n_compared = 0;
  int          n_mismatched = 0;
  exp_t        exp_q[$];
  logic [31:0] seg_words[$];
  logic        seg_errs[$];
  logic        hold_pending = 1'b0;
  logic [31:0] hold_rdata;
  logic [31:0] hold_addr;
  bit          acc;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    assert (observed === expected)
    else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic pushExp(input logic [31:0] addr, input logic [31:0] data,
                         input logic comp, input logic err);
    exp_t e;
    e.addr = addr;
    e.data = data;
    e.comp = comp;
    e.err  = err;
    exp_q.push_back(e);
  endtask

  // Reference: walk the fetched memory halfword by halfword from the branch target.
  task automatic buildExpected(input logic [31:0] start);
    int          n;
    int          i;
    logic [31:0] pc;
    logic [31:0] w;
    logic [15:0] h;
    logic [15:0] h2;
    n  = seg_words.size() * 2;
    i  = int'(start[1]);
    pc = {start[31:1], 1'b0};
    while (i < n) begin
      w = seg_words[i / 2];
      h = (i % 2 == 1) ? w[31:16] : w[15:0];
      if (seg_errs[i / 2]) begin
        pushExp(pc, 32'h0, 1'b0, 1'b1);
        break;
      end
      if (h[1:0] != 2'b11) begin
        pushExp(pc, {16'h0, h}, 1'b1, 1'b0);
        pc = pc + 32'd2;
        i  = i + 1;
      end else begin
        if (i + 1 >= n) break;
        w  = seg_words[(i + 1) / 2];
        h2 = ((i + 1) % 2 == 1) ? w[31:16] : w[15:0];
        if (seg_errs[(i + 1) / 2]) begin
          pushExp(pc, {h2, h}, 1'b0, 1'b1);
          break;
        end
        pushExp(pc, {h2, h}, 1'b0, 1'b0);
        pc = pc + 32'd4;
        i  = i + 2;
      end
    end
  endtask

  task automatic runCycle(output bit accepted);
    exp_t e;
    @(negedge clk_i);
    accepted = fetch_valid_i && fetch_ready_o && rst_ni && !branch_i;
    if (branch_i) checkOutput("branch_fetch_ready", 32'(fetch_ready_o), 32'd1);
    if (hold_pending) begin
      checkOutput("hold_rdata", out_rdata_o, hold_rdata);
      checkOutput("hold_addr", out_addr_o, hold_addr);
    end
    hold_pending = out_valid_o && !out_ready_i && !branch_i && rst_ni;
    hold_rdata   = out_rdata_o;
    hold_addr    = out_addr_o;
    if (out_valid_o && out_ready_i && !branch_i && rst_ni) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_out", 32'(out_valid_o), 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("out_addr", out_addr_o, e.addr);
        checkOutput("out_rdata", out_rdata_o, e.data);
        checkOutput("out_comp", 32'(out_is_compressed_o), 32'(e.comp));
        checkOutput("out_err", 32'(out_err_o), 32'(e.err));
`ifdef IBEX_ALIGNER_PERF_EN
        if (!e.err && e.comp) perf_c_model++;
        if (!e.err && !e.comp) perf_u_model++;
`endif
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic doBranch(input logic [31:0] addr);
    bit dropped;
    branch_i      = 1'b1;
    branch_addr_i = addr;
    fetch_valid_i = 1'b1;
    fetch_rdata_i = $urandom;
    fetch_err_i   = 1'b0;
    out_ready_i   = 1'($urandom_range(0, 1));
    runCycle(dropped);
    branch_i      = 1'b0;
    fetch_valid_i = 1'b0;
    checkOutput("post_branch_valid", 32'(out_valid_o), 32'd0);
    checkOutput("post_branch_addr", out_addr_o, {addr[31:1], 1'b0});
  endtask

  // Feeds seg_words/seg_errs with random valid/ready gaps until all outputs are seen.
  task automatic applyStimulus(input int ready_pct, input int valid_pct);
    int idx = 0;
    int cycles = 0;
    bit got;
    while ((idx < seg_words.size() || exp_q.size() > 0) && cycles < 500) begin
      fetch_valid_i = (idx < seg_words.size()) && ($urandom_range(0, 99) < valid_pct);
      fetch_rdata_i = (idx < seg_words.size()) ? seg_words[idx] : 32'h0;
      fetch_err_i   = (idx < seg_words.size()) ? seg_errs[idx] : 1'b0;
      out_ready_i   = ($urandom_range(0, 99) < ready_pct);
      runCycle(got);
      if (got) idx++;
      cycles++;
    end
    fetch_valid_i = 1'b0;
    fetch_err_i   = 1'b0;
    checkOutput("stream_drained", 32'(exp_q.size()), 32'd0);
    out_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) runCycle(got);
    exp_q.delete();
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_fetch_ready", 32'(fetch_ready_o), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid_o), 32'd0);
    checkOutput("rst_out_addr", out_addr_o, 32'h0);
    checkOutput("rst_out_rdata", out_rdata_o, 32'h0);
    checkOutput("rst_out_err", 32'(out_err_o), 32'd0);
`ifdef IBEX_ALIGNER_PERF_EN
    checkOutput("rst_perf_c", perf_c_cnt_o, 32'd0);
    checkOutput("rst_perf_u", perf_u_cnt_o, 32'd0);
`endif
    rst_ni = 1'b1;

    // Two words back-to-back from the reset PC
    $display("[TB] directed: reset stream");
    seg_words = '{32'h0001_4501, 32'h0000_0013};
    seg_errs  = '{1'b0, 1'b0};
    pushExp(32'h0, 32'h0000_4501, 1'b1, 1'b0);
    pushExp(32'h2, 32'h0000_0001, 1'b1, 1'b0);
    pushExp(32'h4, 32'h0000_0013, 1'b0, 1'b0);
    applyStimulus(100, 100);

    // Straddling instruction, step by step
    $display("[TB] directed: straddle");
    doBranch(32'h0);
    pushExp(32'h0, 32'h0000_0001, 1'b1, 1'b0);
    pushExp(32'h2, 32'h0000_0093, 1'b0, 1'b0);
    pushExp(32'h6, 32'h0000_1234, 1'b1, 1'b0);
    fetch_valid_i = 1'b1;
    fetch_rdata_i = 32'h0093_0001;
    out_ready_i   = 1'b1;
    runCycle(acc);
    checkOutput("w1_accept", 32'(acc), 32'd1);
    checkOutput("lat_valid", 32'(out_valid_o), 32'd1);
    fetch_rdata_i = 32'h1234_0000;
    runCycle(acc);
    checkOutput("lo_no_fetch", 32'(acc), 32'd0);
    checkOutput("hi_wait_valid", 32'(out_valid_o), 32'd0);
    checkOutput("hi_wait_ready", 32'(fetch_ready_o), 32'd1);
    runCycle(acc);
    checkOutput("w2_accept", 32'(acc), 32'd1);
    fetch_valid_i = 1'b0;
    checkOutput("straddle_valid", 32'(out_valid_o), 32'd1);
    runCycle(acc);
    runCycle(acc);
    checkOutput("straddle_drained", 32'(exp_q.size()), 32'd0);

    // Branch into the upper half of a word
    $display("[TB] directed: branch to upper half");
    doBranch(32'h0000_0102);
    seg_words = '{32'h4505_0001};
    seg_errs  = '{1'b0};
    pushExp(32'h102, 32'h0000_4505, 1'b1, 1'b0);
    applyStimulus(100, 100);

    // Downstream stall while a 32-bit instruction is held in ALIGN_LO
    $display("[TB] directed: stall");
    doBranch(32'h0000_0200);
    pushExp(32'h200, 32'h0000_0013, 1'b0, 1'b0);
    pushExp(32'h204, 32'h0000_4501, 1'b1, 1'b0);
    pushExp(32'h206, 32'h0000_0001, 1'b1, 1'b0);
    fetch_valid_i = 1'b1;
    fetch_rdata_i = 32'h0000_0013;
    out_ready_i   = 1'b0;
    runCycle(acc);
    fetch_rdata_i = 32'h0001_4501;
    for (int k = 0; k < 5; k++) begin
      checkOutput("stall_fetch_ready", 32'(fetch_ready_o), 32'd0);
      runCycle(acc);
      checkOutput("stall_no_accept", 32'(acc), 32'd0);
    end
    out_ready_i = 1'b1;
    runCycle(acc);
    checkOutput("stall_release_accept", 32'(acc), 32'd1);
    fetch_valid_i = 1'b0;
    runCycle(acc);
    runCycle(acc);
    checkOutput("stall_drained", 32'(exp_q.size()), 32'd0);

    // Straddle whose second word carries a bus error
    $display("[TB] directed: straddle error");
    doBranch(32'h0000_0300);
    seg_words = '{32'h0093_0001, 32'h1234_0000};
    seg_errs  = '{1'b0, 1'b1};
    pushExp(32'h300, 32'h0000_0001, 1'b1, 1'b0);
    pushExp(32'h302, 32'h0000_0093, 1'b0, 1'b1);
    applyStimulus(100, 100);
    checkOutput("err_empty_valid", 32'(out_valid_o), 32'd0);
    checkOutput("err_empty_ready", 32'(fetch_ready_o), 32'd1);
    checkOutput("err_pc_held", out_addr_o, 32'h302);

`ifdef IBEX_ALIGNER_PERF_EN
    checkOutput("perf_c", perf_c_cnt_o, 32'(perf_c_model));
    checkOutput("perf_u", perf_u_cnt_o, 32'(perf_u_model));
    doBranch(32'h0000_0500);
    checkOutput("perf_c_branch", perf_c_cnt_o, 32'(perf_c_model));
    checkOutput("perf_u_branch", perf_u_cnt_o, 32'(perf_u_model));
`endif

    // PC wrap-around at the top of the address space
    $display("[TB] directed: pc wrap");
    doBranch(32'hFFFF_FFFA);
    seg_words = '{$urandom, $urandom, $urandom, $urandom};
    seg_errs  = '{1'b0, 1'b0, 1'b0, 1'b0};
    buildExpected(32'hFFFF_FFFA);
    applyStimulus(80, 80);

    // Reset while an instruction is pending
    $display("[TB] directed: mid-stream reset");
    doBranch(32'h0000_0400);
    fetch_valid_i = 1'b1;
    fetch_rdata_i = 32'h0000_0013;
    out_ready_i   = 1'b0;
    runCycle(acc);
    fetch_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(out_valid_o), 32'd0);
    checkOutput("midrst_ready", 32'(fetch_ready_o), 32'd1);
    checkOutput("midrst_addr", out_addr_o, 32'h0);
    checkOutput("midrst_rdata", out_rdata_o, 32'h0);
    checkOutput("midrst_err", 32'(out_err_o), 32'd0);
`ifdef IBEX_ALIGNER_PERF_EN
    checkOutput("midrst_perf_c", perf_c_cnt_o, 32'd0);
    perf_c_model = 0;
    perf_u_model = 0;
`endif
    exp_q.delete();
    hold_pending = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Random streams against the reference model
    $display("[TB] random streams");
    for (int s = 0; s < 40; s++) begin
      logic [31:0] addr;
      int          nw;
      int          err_at;
      addr   = $urandom;
      nw     = $urandom_range(1, 8);
      err_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, nw - 1) : -1;
      if (err_at >= 0) nw = err_at + 1;
      seg_words.delete();
      seg_errs.delete();
      for (int k = 0; k < nw; k++) begin
        seg_words.push_back($urandom);
        seg_errs.push_back(k == err_at);
      end
      doBranch(addr);
      buildExpected(addr);
      applyStimulus($urandom_range(40, 100), $urandom_range(40, 100));
    end

`ifdef IBEX_ALIGNER_PERF_EN
    checkOutput("perf_c_final", perf_c_cnt_o, 32'(perf_c_model));
    checkOutput("perf_u_final", perf_u_cnt_o, 32'(perf_u_model));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
